lsu_mem_port: RTL and testbench



---
 rtl/lsu_mem_port.sv | 204 ++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit between execute and data memory: one access at a time, store lane
// alignment, load extraction/extension, and misaligned/illegal/timeout error reporting.
module lsu_mem_port #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_valid,
  output logic [1:0]  err_cause,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, ERR} state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [1:0]     cause_r, cause_s;
  logic           we_r;
  logic [2:0]     funct3_r;
  logic [1:0]     off_r;
  logic [4:0]     rd_r;
  logic           req_ready_r, mem_valid_r, mem_we_r, wb_valid_r, err_valid_r, busy_r;
  logic [31:0]    mem_addr_r, mem_wdata_r, wb_data_r;
  logic [3:0]     mem_be_r;
  logic [4:0]     wb_rd_r;
  logic [1:0]     err_cause_r;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > 3'b010);
    else    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return d;
    endcase
  endfunction

  // Next-state, error cause and timeout counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    cause_s = cause_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (f3_illegal(req_we, req_funct3)) begin
            state_s = ERR;
            cause_s = 2'b10;
          end else if (misaligned(req_funct3, req_addr[1:0])) begin
            state_s = ERR;
            cause_s = 2'b01;
          end else begin
            state_s = REQ;
            cnt_s   = '0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      // A handshake in the final counted cycle still beats the timeout
      REQ: begin
        if (mem_ready) begin
          state_s = we_r ? IDLE : WAIT;
          cnt_s   = '0;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          state_s = ERR;
          cause_s = 2'b11;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_s = WB;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          state_s = ERR;
          cause_s = 2'b11;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      WB:      state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      cause_r     <= 2'b00;
      we_r        <= 1'b0;
      funct3_r    <= 3'b000;
      off_r       <= 2'b00;
      rd_r        <= 5'd0;
      req_ready_r <= 1'b1;
      mem_valid_r <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_be_r    <= 4'd0;
      mem_wdata_r <= 32'd0;
      wb_valid_r  <= 1'b0;
      wb_rd_r     <= 5'd0;
      wb_data_r   <= 32'd0;
      err_valid_r <= 1'b0;
      err_cause_r <= 2'b00;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cause_r     <= cause_s;
      req_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      mem_valid_r <= (state_s == REQ);
      wb_valid_r  <= (state_s == WB) && (rd_r != 5'd0);
      err_valid_r <= (state_s == ERR);
      err_cause_r <= (state_s == ERR) ? cause_s : 2'b00;
      if (state_r == IDLE && req_valid) begin
        we_r     <= req_we;
        funct3_r <= req_funct3;
        off_r    <= req_addr[1:0];
        rd_r     <= req_rd;
        if (state_s == REQ) begin
          mem_we_r    <= req_we;
          mem_addr_r  <= {req_addr[31:2], 2'b00};
          mem_be_r    <= byte_en(req_funct3, req_addr[1:0]);
          mem_wdata_r <= lane_data(req_funct3, req_wdata);
        end
      end
      if (state_r == WAIT && mem_rvalid) begin
        wb_data_r <= load_ext(funct3_r, off_r, mem_rdata);
        wb_rd_r   <= rd_r;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign mem_valid = mem_valid_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;
  assign wb_valid  = wb_valid_r;
  assign wb_rd     = wb_rd_r;
  assign wb_data   = wb_data_r;
  assign err_valid = err_valid_r;
  assign err_cause = err_cause_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized self-checking bench for lsu_mem_port: each access is predicted from
// byte-level arithmetic and its cycle-by-cycle handshake checked against the DUT.
module tb_lsu_mem_port;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        srst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, err_valid, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  err_cause;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem_port #(.TIMEOUT(TO)) dut (
    .clk(clk), .srst_n(srst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_valid(err_valid), .err_cause(err_cause), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: access size in bytes, or 0 for an illegal funct3
  function automatic int nbytes(input logic we, input logic [2:0] f3);
    if (we) return (f3 <= 3'd2) ? (1 << f3) : 0;
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input int n, input logic [31:0] a);
    int off;
    off = int'(a[1:0]) - (int'(a[1:0]) % n);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_lanes(input int n, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input int n, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] d);
    longint v, mask;
    v = longint'(d) >> (8 * int'(a[1:0]));
    if (n == 4) return d;
    mask = (64'sd1 <<< (8 * n)) - 1;
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // One complete access: rdy_dly/rv_dly are cycles before the memory responds (>=TO -> never)
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                         input int rdy_dly, input int rv_dly);
    int n;
    logic mis;
    logic [1:0] cause;
    logic done;
    n = nbytes(we, f3);
    mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'd0);
    cause = (n == 0) ? 2'b10 : (mis ? 2'b01 : 2'b00);
    check_eq("idle_ready", {31'd0, req_ready}, 32'd1);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    check_eq("busy", {31'd0, busy}, 32'd1);
    check_eq("ready_low", {31'd0, req_ready}, 32'd0);
    if (cause != 2'b00) begin
      check_eq("err_valid", {31'd0, err_valid}, 32'd1);
      check_eq("err_cause", {30'd0, err_cause}, {30'd0, cause});
      check_eq("err_no_mem", {31'd0, mem_valid}, 32'd0);
      @(negedge clk);
      check_eq("err_one_cycle", {31'd0, err_valid}, 32'd0);
      return;
    end
    done = 1'b0;
    for (int k = 0; k < TO && !done; k++) begin
      check_eq("mem_valid", {31'd0, mem_valid}, 32'd1);
      check_eq("mem_addr", mem_addr, {addr[31:2], 2'b00});
      check_eq("mem_we", {31'd0, mem_we}, {31'd0, we});
      check_eq("mem_be", {28'd0, mem_be}, {28'd0, ref_be(n, addr)});
      if (we) check_eq("mem_wdata", mem_wdata, ref_lanes(n, wd));
      mem_ready = (k == rdy_dly);
      done = mem_ready;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    if (!done) begin
      check_eq("req_timeout", {30'd0, err_valid, 1'b0} | {30'd0, err_cause}, 32'd3 | 32'd2);
      check_eq("req_to_cause", {30'd0, err_cause}, 32'd3);
      check_eq("req_to_novalid", {31'd0, mem_valid}, 32'd0);
      @(negedge clk);
      return;
    end
    if (we) begin
      check_eq("st_ready_back", {31'd0, req_ready}, 32'd1);
      check_eq("st_no_wb", {31'd0, wb_valid}, 32'd0);
      check_eq("st_mem_drop", {31'd0, mem_valid}, 32'd0);
      return;
    end
    done = 1'b0;
    for (int j = 0; j < TO && !done; j++) begin
      check_eq("wait_novalid", {31'd0, mem_valid}, 32'd0);
      check_eq("wait_no_wb", {31'd0, wb_valid}, 32'd0);
      mem_rvalid = (j == rv_dly);
      mem_rdata = mem_rvalid ? rdata : $urandom;
      done = mem_rvalid;
      @(negedge clk);
    end
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    if (!done) begin
      check_eq("rd_timeout", {31'd0, err_valid}, 32'd1);
      check_eq("rd_to_cause", {30'd0, err_cause}, 32'd3);
      @(negedge clk);
      return;
    end
    check_eq("wb_valid", {31'd0, wb_valid}, {31'd0, rd != 5'd0});
    check_eq("wb_no_err", {31'd0, err_valid}, 32'd0);
    check_eq("wb_data", wb_data, ref_load(n, f3, addr, rdata));
    if (rd != 5'd0) check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
    @(negedge clk);
    check_eq("wb_one_cycle", {31'd0, wb_valid}, 32'd0);
  endtask

  function automatic int pick_dly();
    int r;
    r = int'($urandom_range(0, 19));
    return (r < 15) ? (r % 4) : (r - 2);   // mostly short, sometimes 13..17
  endfunction

  initial begin
    srst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; req_rd = 5'd0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("rst_err", {29'd0, err_valid, err_cause}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    srst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd0, 32'd0, 0, 0);
    run_txn(1'b0, 3'b000, 32'h0000_2001, 32'd0, 5'd5, 32'h1234_80FF, 0, 0);
    run_txn(1'b0, 3'b100, 32'h0000_2001, 32'd0, 5'd5, 32'h1234_80FF, 0, 0);
    run_txn(1'b0, 3'b001, 32'h0000_2002, 32'd0, 5'd7, 32'h8001_7FFF, 1, 2);
    run_txn(1'b0, 3'b101, 32'h0000_2002, 32'd0, 5'd7, 32'h8001_7FFF, 0, 0);
    run_txn(1'b0, 3'b010, 32'h0000_2000, 32'd0, 5'd0, 32'hDEAD_BEEF, 0, 0);
    run_txn(1'b1, 3'b010, 32'h0000_3002, 32'h1111_2222, 5'd0, 32'd0, 0, 0);
    run_txn(1'b0, 3'b011, 32'h0000_3001, 32'd0, 5'd3, 32'd0, 0, 0);
    run_txn(1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd9, 32'd0, TO, 0);
    run_txn(1'b0, 3'b010, 32'h0000_4004, 32'd0, 5'd9, 32'hCAFE_F00D, TO - 1, TO - 1);
    run_txn(1'b0, 3'b000, 32'h0000_4004, 32'd0, 5'd9, 32'd0, 0, TO);

    // Reset while waiting for read data, then a late rvalid must be ignored
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_5000; req_rd = 5'd4;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    srst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_outs", {28'd0, mem_valid, wb_valid, err_valid, mem_we}, 32'd0);
    @(negedge clk);
    srst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq("late_rvalid_wb", {31'd0, wb_valid}, 32'd0);
    check_eq("late_rvalid_busy", {31'd0, busy}, 32'd0);

    for (int t = 0; t < 250; t++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
              pick_dly(), pick_dly());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
